// File: rtl/hdmi_cfg_seq.sv
// HDMI transmitter power-up register sequencer: walks a {reg,data} table and writes each entry over I2C.
// Build macro CFG_HPD_EN adds an HPD input that gates START, starts on its rising edge and aborts runs.
module hdmi_cfg_seq #(
   parameter logic [6:0] DEV_ADDR   = 7'h39,
   parameter logic [7:0] NUM_WRITES = 8'd32,
   parameter logic [1:0] RETRY_MAX  = 2'd3
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        TICK,
   input  logic        START,
`ifdef CFG_HPD_EN
   input  logic        HPD,
`endif
   output logic [7:0]  CFG_ADDR,
   input  logic [15:0] CFG_DATA,
   input  logic        SDA_IN,
   output logic        SCL_OE,
   output logic        SDA_OE,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_LOAD = 4'd1;
   localparam logic [3:0] S_STA  = 4'd2;
   localparam logic [3:0] S_BYTE = 4'd3;
   localparam logic [3:0] S_ACK  = 4'd4;
   localparam logic [3:0] S_STO  = 4'd5;
   localparam logic [3:0] S_GAP  = 4'd6;
   localparam logic [3:0] S_FIN  = 4'd7;
   localparam logic [3:0] S_FAIL = 4'd8;

   logic [3:0]  state_reg;
   logic [1:0]  ph_reg;
   logic [2:0]  bit_reg;
   logic [1:0]  byte_reg;
   logic [23:0] frame_reg;
   logic [1:0]  retry_reg;
   logic        nack_reg;
   logic        ack_smp_reg;
   logic        start_go;
   logic        abort_now;
   logic        scl_low_ph;

`ifdef CFG_HPD_EN
   logic hpd_q_reg;
   logic abort_reg;

   // hpd_q_reg follows HPD through reset so a plug held high does not fake a rising edge.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         hpd_q_reg <= HPD;
         abort_reg <= 1'b0;
      end else begin
         hpd_q_reg <= HPD;
         if (state_reg == S_IDLE)
            abort_reg <= 1'b0;
         else if (!HPD)
            abort_reg <= 1'b1;
      end
   end

   assign start_go  = HPD & (START | ~hpd_q_reg);
   assign abort_now = abort_reg | ~HPD;
`else
   assign start_go  = START;
   assign abort_now = 1'b0;
`endif

   // SCL is held low in the first and last quarter of every data/ack bit slot.
   assign scl_low_ph = (ph_reg == 2'd0) || (ph_reg == 2'd3);

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_reg   <= S_IDLE;
         ph_reg      <= 2'd0;
         bit_reg     <= 3'd7;
         byte_reg    <= 2'd0;
         frame_reg   <= 24'd0;
         retry_reg   <= 2'd0;
         nack_reg    <= 1'b0;
         ack_smp_reg <= 1'b0;
         SCL_OE      <= 1'b0;
         SDA_OE      <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
         CFG_ADDR    <= 8'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start_go) begin
                  DONE      <= 1'b0;
                  ERR       <= 1'b0;
                  BUSY      <= 1'b1;
                  CFG_ADDR  <= 8'd0;
                  retry_reg <= 2'd0;
                  state_reg <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort_now) begin
                  BUSY      <= 1'b0;
                  CFG_ADDR  <= 8'd0;
                  state_reg <= S_IDLE;
               end else begin
                  frame_reg <= {DEV_ADDR, 1'b0, CFG_DATA};
                  ph_reg    <= 2'd0;
                  bit_reg   <= 3'd7;
                  byte_reg  <= 2'd0;
                  nack_reg  <= 1'b0;
                  state_reg <= S_STA;
               end
            end
            S_STA: begin
               if (TICK) begin
                  SDA_OE <= 1'b1;
                  SCL_OE <= ph_reg[1];
                  ph_reg <= ph_reg + 2'd1;
                  if (ph_reg == 2'd3)
                     state_reg <= abort_now ? S_STO : S_BYTE;
               end
            end
            S_BYTE: begin
               if (TICK) begin
                  SCL_OE <= scl_low_ph;
                  if (ph_reg == 2'd0)
                     SDA_OE <= ~frame_reg[23];
                  ph_reg <= ph_reg + 2'd1;
                  if (ph_reg == 2'd3) begin
                     frame_reg <= {frame_reg[22:0], 1'b0};
                     bit_reg   <= bit_reg - 3'd1;
                     if (abort_now)
                        state_reg <= S_STO;
                     else if (bit_reg == 3'd0)
                        state_reg <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               if (TICK) begin
                  SCL_OE <= scl_low_ph;
                  SDA_OE <= 1'b0;
                  ph_reg <= ph_reg + 2'd1;
                  if (ph_reg == 2'd2)
                     ack_smp_reg <= SDA_IN;
                  if (ph_reg == 2'd3) begin
                     if (ack_smp_reg || (byte_reg == 2'd2) || abort_now) begin
                        nack_reg  <= ack_smp_reg;
                        state_reg <= S_STO;
                     end else begin
                        byte_reg  <= byte_reg + 2'd1;
                        state_reg <= S_BYTE;
                     end
                  end
               end
            end
            S_STO: begin
               if (TICK) begin
                  SCL_OE <= (ph_reg == 2'd0);
                  SDA_OE <= (ph_reg != 2'd3);
                  ph_reg <= ph_reg + 2'd1;
                  if (ph_reg == 2'd3) begin
                     if (abort_now) begin
                        BUSY      <= 1'b0;
                        CFG_ADDR  <= 8'd0;
                        state_reg <= S_IDLE;
                     end else begin
                        state_reg <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (TICK) begin
                  SCL_OE <= 1'b0;
                  SDA_OE <= 1'b0;
                  ph_reg <= ph_reg + 2'd1;
                  if (ph_reg == 2'd3) begin
                     if (abort_now) begin
                        BUSY      <= 1'b0;
                        CFG_ADDR  <= 8'd0;
                        state_reg <= S_IDLE;
                     end else if (!nack_reg) begin
                        retry_reg <= 2'd0;
                        if (CFG_ADDR == NUM_WRITES - 8'd1) begin
                           state_reg <= S_FIN;
                        end else begin
                           CFG_ADDR  <= CFG_ADDR + 8'd1;
                           state_reg <= S_LOAD;
                        end
                     end else if (retry_reg < RETRY_MAX) begin
                        retry_reg <= retry_reg + 2'd1;
                        state_reg <= S_LOAD;
                     end else begin
                        state_reg <= S_FAIL;
                     end
                  end
               end
            end
            S_FIN: begin
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               CFG_ADDR  <= 8'd0;
               state_reg <= S_IDLE;
            end
            S_FAIL: begin
               // CFG_ADDR is left on the failing entry for diagnosis.
               ERR       <= 1'b1;
               BUSY      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Bench for hdmi_cfg_seq: I2C slave/bus monitor plus a frame-level model of the write/retry rules.
`timescale 1ns/1ps
module tb_hdmi_cfg_seq;

   localparam logic [6:0] TB_DEV   = 7'h39;
   localparam logic [7:0] TB_N     = 8'd6;
   localparam logic [1:0] TB_RETRY = 2'd3;

   logic        CLK   = 1'b0;
   logic        RST_n = 1'b0;
   logic        TICK  = 1'b0;
   logic        START = 1'b0;
   logic [7:0]  CFG_ADDR;
   logic [15:0] CFG_DATA;
   logic        SDA_IN;
   logic        SCL_OE;
   logic        SDA_OE;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
`ifdef CFG_HPD_EN
   logic        HPD = 1'b1;
`endif

   logic [15:0] cfg_tab [0:255];
   logic        slave_pull = 1'b0;
   logic        tick_en    = 1'b1;

   assign CFG_DATA = cfg_tab[CFG_ADDR];
   assign SDA_IN   = ~SDA_OE & ~slave_pull;

   hdmi_cfg_seq #(.DEV_ADDR(TB_DEV), .NUM_WRITES(TB_N), .RETRY_MAX(TB_RETRY)) dut (
      .CLK(CLK), .RST_n(RST_n), .TICK(TICK), .START(START),
`ifdef CFG_HPD_EN
      .HPD(HPD),
`endif
      .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .SDA_IN(SDA_IN),
      .SCL_OE(SCL_OE), .SDA_OE(SDA_OE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Quarter-bit ticks with at least two idle cycles in between.
   initial begin
      int gap;
      gap = 0;
      forever begin
         @(posedge CLK); #1;
         if (tick_en && gap == 0) begin
            TICK = 1'b1;
            gap  = $urandom_range(2, 3);
         end else begin
            TICK = 1'b0;
            if (gap > 0) gap--;
         end
      end
   end

   // I2C slave and bus monitor: decodes frames from the open-drain lines.
   int          policy [0:63];
   int          frame_idx, tick_cnt, viol_cnt, addr_err, bus_chg;
   int          bitcnt, nb;
   logic [31:0] got_q [$];
   logic [7:0]  cur_byte;
   logic [7:0]  fb [0:2];
   logic        in_frame    = 1'b0;
   logic        prev_scl    = 1'b1;
   logic        prev_sda    = 1'b1;
   logic        prev_scl_oe = 1'b0;
   logic        prev_sda_oe = 1'b0;
   logic [7:0]  prev_addr   = 8'd0;

   always @(negedge CLK) begin
      logic scl, sda;
      scl = ~SCL_OE;
      sda = SDA_IN;
      if (!RST_n) begin
         in_frame   = 1'b0;
         slave_pull = 1'b0;
         bitcnt     = 0;
      end else begin
         if (TICK && BUSY) tick_cnt++;
         if (SCL_OE != prev_scl_oe || SDA_OE != prev_sda_oe) bus_chg++;
         if (CFG_ADDR != prev_addr && CFG_ADDR != prev_addr + 8'd1 && CFG_ADDR != 8'd0) addr_err++;
         if (scl && prev_scl && sda != prev_sda) begin
            if (!sda && !in_frame) begin
               in_frame = 1'b1; bitcnt = 0; nb = 0;
               fb[0] = 8'h0; fb[1] = 8'h0; fb[2] = 8'h0;
            end else if (sda && in_frame && bitcnt == 1) begin
               in_frame = 1'b0;
               got_q.push_back({nb[7:0], fb[0], fb[1], fb[2]});
               frame_idx++;
            end else begin
               viol_cnt++;
            end
         end else if (in_frame && scl && !prev_scl) begin
            if (bitcnt < 8) begin
               cur_byte = {cur_byte[6:0], sda};
               bitcnt++;
            end else begin
               if (nb < 3) fb[nb] = cur_byte;
               else viol_cnt++;
               nb++;
               bitcnt = 0;
            end
         end else if (in_frame && !scl && prev_scl) begin
            slave_pull = (bitcnt == 8) && (frame_idx < 64) && (policy[frame_idx] != nb);
         end
      end
      prev_scl = scl; prev_sda = sda; prev_addr = CFG_ADDR;
      prev_scl_oe = SCL_OE; prev_sda_oe = SDA_OE;
   end

   // Reference model: policy[f] is the byte index the slave NACKs in frame f (3 = ACK all).
   logic [31:0] exp_q [$];
   int          exp_ticks;
   logic        exp_done, exp_err;
   logic [7:0]  exp_addr;

   task automatic build_expected();
      int f, entry, retry, k, nbs;
      logic [7:0] b1, b2;
      exp_q.delete();
      exp_ticks = 0; f = 0; entry = 0; retry = 0;
      exp_err = 1'b0; exp_addr = 8'd0;
      while (entry < int'(TB_N) && !exp_err) begin
         k   = policy[f];
         f++;
         nbs = (k >= 3) ? 3 : k + 1;
         b1  = (nbs > 1) ? cfg_tab[entry][15:8] : 8'h00;
         b2  = (nbs > 2) ? cfg_tab[entry][7:0]  : 8'h00;
         exp_q.push_back({8'(nbs), {TB_DEV, 1'b0}, b1, b2});
         exp_ticks += 4 + 36 * nbs + 4 + 4;
         if (k >= 3) begin
            retry = 0;
            entry++;
         end else if (retry < int'(TB_RETRY)) begin
            retry++;
         end else begin
            exp_err  = 1'b1;
            exp_addr = entry[7:0];
         end
      end
      exp_done = !exp_err;
   endtask

   // mode 0: plain run; 1: pause TICK and pulse START mid-run; 2: reset during entry 5 byte 2.
   task automatic run_seq(input string tag, input int mode);
      int cyc;
      build_expected();
      got_q.delete();
      frame_idx = 0; tick_cnt = 0; viol_cnt = 0; addr_err = 0;
      cyc = 0;
      while (!TICK && cyc < 100) begin
         @(posedge CLK); #2;
         cyc++;
      end
      @(posedge CLK); #1; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      @(negedge CLK);
      check_val({tag, "/busy_on"}, BUSY, 1);
      check_val({tag, "/done_clr"}, DONE, 0);
      check_val({tag, "/err_clr"}, ERR, 0);

      if (mode == 1) begin
         cyc = 0;
         while (frame_idx < 2 && cyc < 20000) begin @(posedge CLK); #1; cyc++; end
         tick_en = 1'b0;
         repeat (3) @(posedge CLK);
         #1; bus_chg = 0;
         START = 1'b1;
         @(posedge CLK); #1; START = 1'b0;
         repeat (100) @(posedge CLK);
         #1;
         check_val({tag, "/pause_bus"}, bus_chg, 0);
         check_val({tag, "/pause_busy"}, BUSY, 1);
         tick_en = 1'b1;
      end

      if (mode == 2) begin
         cyc = 0;
         while (!(in_frame && CFG_ADDR == 8'd5 && nb == 1 && bitcnt >= 3) && cyc < 20000) begin
            @(posedge CLK); #1; cyc++;
         end
         check_val({tag, "/reach_entry5"}, CFG_ADDR, 5);
         RST_n = 1'b0;
         @(posedge CLK); #1;
         check_val({tag, "/rst_scl"}, SCL_OE, 0);
         check_val({tag, "/rst_sda"}, SDA_OE, 0);
         check_val({tag, "/rst_busy"}, BUSY, 0);
         check_val({tag, "/rst_addr"}, CFG_ADDR, 0);
         check_val({tag, "/rst_done"}, DONE, 0);
         @(posedge CLK); #1; RST_n = 1'b1;
         $display("run %s: reset applied in entry 5 byte 2", tag);
         return;
      end

      cyc = 0;
      while (BUSY && cyc < 20000) begin @(posedge CLK); #1; cyc++; end
      check_val({tag, "/timeout"}, BUSY, 0);
      @(negedge CLK);
      check_val({tag, "/done"}, DONE, exp_done);
      check_val({tag, "/err"}, ERR, exp_err);
      check_val({tag, "/addr"}, CFG_ADDR, exp_addr);
      check_val({tag, "/scl_rel"}, SCL_OE, 0);
      check_val({tag, "/sda_rel"}, SDA_OE, 0);
      check_val({tag, "/nframes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check_val($sformatf("%s/frame%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
      check_val({tag, "/ticks"}, tick_cnt, exp_ticks);
      check_val({tag, "/bus_protocol"}, viol_cnt, 0);
      check_val({tag, "/addr_seq"}, addr_err, 0);
      $display("run %s: frames=%0d ticks=%0d done=%0b err=%0b addr=%0d",
               tag, got_q.size(), tick_cnt, DONE, ERR, CFG_ADDR);
   endtask

   task automatic set_policy_all(input int v);
      for (int i = 0; i < 64; i++) policy[i] = v;
   endtask

   task automatic rand_table();
      for (int i = 0; i < 256; i++) cfg_tab[i] = 16'($urandom);
   endtask

   initial begin
      rand_table();
      set_policy_all(3);
      RST_n = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check_val("reset/scl", SCL_OE, 0);
      check_val("reset/sda", SDA_OE, 0);
      check_val("reset/busy", BUSY, 0);
      check_val("reset/done", DONE, 0);
      check_val("reset/err", ERR, 0);
      check_val("reset/addr", CFG_ADDR, 0);
      @(posedge CLK); #1; RST_n = 1'b1;
      repeat (3) @(posedge CLK);

      run_seq("all_ack", 0);

      set_policy_all(3);
      policy[1] = 2; policy[2] = 2;
      run_seq("retry_data", 0);

      set_policy_all(0);
      run_seq("addr_nack", 0);

      rand_table();
      set_policy_all(3);
      policy[3] = 1;
      run_seq("pause_start", 1);

      for (int r = 0; r < 3; r++) begin
         rand_table();
         for (int i = 0; i < 64; i++)
            policy[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : 3;
         run_seq($sformatf("random%0d", r), 0);
      end

      rand_table();
      set_policy_all(3);
      run_seq("mid_reset", 2);
      repeat (3) @(posedge CLK);
      run_seq("recover", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
